// File: rtl/pre_delay_line.sv
// ============================================================================
// Module   : pre_delay_line
// Function : Pre-delay stage for the dry audio path. Each accepted sample is
//            written into a circular buffer and the sample from d positions
//            earlier is returned, where d is the requested pre-delay. One
//            sample is in flight at a time, with valid/ready on both sides.
// Options  : define PREDELAY_SLEW_EN to slew the applied delay by at most one
//            step per accepted sample instead of jumping to delay_value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_delay_line #(
    parameter int DATA_W      = 24,
    parameter int DELAY_W     = 10,
    parameter int RESET_DELAY = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DELAY_W-1:0] i_delay_value,
    input  logic [DATA_W-1:0]  i_in_data,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic [DATA_W-1:0]  o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DELAY_W-1:0] o_cur_delay
);

    localparam int                 c_DEPTH       = 2 ** DELAY_W;
    localparam logic [DELAY_W-1:0] c_ONE         = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] c_RESET_DELAY = DELAY_W'(RESET_DELAY);
    localparam logic [DELAY_W-1:0] c_FILL_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [DELAY_W-1:0]  r_cur_delay;
    logic [DELAY_W-1:0]  r_wr_ptr;
    logic [DELAY_W-1:0]  r_fill_cnt;
    logic [DATA_W-1:0]   r_in_data;

    // Buffer storage; contents are deliberately left unreset, the fill
    // counter masks anything written before the most recent reset.
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_accept;
    logic [DELAY_W-1:0]  w_d_eff;
    logic [DELAY_W-1:0]  w_rd_addr;
    logic                w_we;

    assign w_accept  = (r_state == S_IDLE) && r_in_ready && i_in_valid;
    assign w_we      = (r_state == S_READ);
    // Read address is wr_ptr - d modulo the depth; the subtraction wraps
    // naturally because the pointer width equals the address width.
    assign w_rd_addr = r_wr_ptr - w_d_eff;

`ifdef PREDELAY_SLEW_EN
    // Move the applied delay one step toward the requested value per sample.
    always_comb begin
        w_d_eff = r_cur_delay;
        if (i_delay_value > r_cur_delay) begin
            w_d_eff = r_cur_delay + c_ONE;
        end else if (i_delay_value < r_cur_delay) begin
            w_d_eff = r_cur_delay - c_ONE;
        end
    end
`else
    // Apply the requested delay immediately at each acceptance.
    always_comb begin
        w_d_eff = i_delay_value;
    end
`endif

    // Synchronous RAM: read is launched in the accept cycle, the write of
    // the accepted sample follows one cycle later, so a read of the same
    // location always sees the old data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= r_in_data;
        end
        if (w_accept) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // Control FSM with registered handshake outputs and buffer bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cur_delay <= c_RESET_DELAY;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_in_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_in_data   <= i_in_data;
                        r_cur_delay <= w_d_eff;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_READ;
                    end else begin
                        r_in_ready  <= 1'b1;
                    end
                end

                S_READ: begin
                    // Zero delay bypasses the buffer; an unprimed buffer
                    // outputs silence; otherwise return the delayed sample.
                    if (r_cur_delay == '0) begin
                        r_out_data <= r_in_data;
                    end else if (r_fill_cnt < r_cur_delay) begin
                        r_out_data <= '0;
                    end else begin
                        r_out_data <= r_rd_data;
                    end
                    r_out_valid <= 1'b1;
                    r_wr_ptr    <= r_wr_ptr + c_ONE;
                    if (r_fill_cnt != c_FILL_MAX) begin
                        r_fill_cnt <= r_fill_cnt + c_ONE;
                    end
                    r_in_ready  <= 1'b0;
                    r_state     <= S_HOLD;
                end

                S_HOLD: begin
                    // Input is ignored here; a new sample can only be taken
                    // in the cycle after the downstream handshake.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_in_ready  <= 1'b0;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_cur_delay = r_cur_delay;

endmodule

`default_nettype wire

// File: tb/tb_pre_delay_line.sv
// ============================================================================
// Module   : tb_pre_delay_line
// Function : Directed self-checking bench for pre_delay_line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pre_delay_line;

    localparam int DATA_W  = 24;
    localparam int DELAY_W = 10;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [DELAY_W-1:0] i_delay_value;
    logic [DATA_W-1:0]  i_in_data;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [DATA_W-1:0]  o_out_data;
    logic               o_out_valid;
    logic               i_out_ready;
    logic [DELAY_W-1:0] o_cur_delay;

    int vectors     = 0;
    int miscompares = 0;

    pre_delay_line #(
        .DATA_W      (DATA_W),
        .DELAY_W     (DELAY_W),
        .RESET_DELAY (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_delay_value (i_delay_value),
        .i_in_data     (i_in_data),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .o_out_data    (o_out_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_cur_delay   (o_cur_delay)
    );

    always #5 clk = ~clk;

    // Pulse reset for one cycle and return one cycle after release.
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Push one sample through; returns the output and cycles from accept
    // to out_valid. Bounded waits so a stuck DUT still reaches the summary.
    task automatic send(input logic [DATA_W-1:0] x, output logic [DATA_W-1:0] y,
                        output int lat);
        int n;
        n = 0;
        while (o_in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        i_in_valid = 1'b1;
        i_in_data  = x;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        lat = 1;
        while (o_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        y = o_out_data;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        i_in_valid    = 1'b0;
        i_in_data     = '0;
        i_out_ready   = 1'b0;
        i_delay_value = 10'd5;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 0", o_in_ready);
        end
        vectors++;
        if (o_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", o_out_valid);
        end
        vectors++;
        if (o_out_data !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_out_data: got %h want 0", o_out_data);
        end
        vectors++;
        if (o_cur_delay !== 10'd5) begin
            miscompares++;
            $display("FAIL reset_cur_delay: got %0d want 5", o_cur_delay);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (o_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready: got %b want 1", o_in_ready);
        end
    endtask

    task automatic test_basic_delay();
        logic [DATA_W-1:0] y;
        int lat;
        int exp;
        i_delay_value = 10'd5;
        for (int k = 1; k <= 12; k++) begin
            send(DATA_W'(k), y, lat);
            exp = (k <= 5) ? 0 : k - 5;
            vectors++;
            if (y !== DATA_W'(exp)) begin
                miscompares++;
                $display("FAIL basic_data[%0d]: got %0d want %0d", k, y, exp);
            end
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL basic_latency[%0d]: got %0d want 2", k, lat);
            end
        end
        vectors++;
        if (o_cur_delay !== 10'd5) begin
            miscompares++;
            $display("FAIL basic_cur_delay: got %0d want 5", o_cur_delay);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] y;
        int lat;
        do_reset();
        i_delay_value = 10'd0;
        send(24'h123456, y, lat);
        vectors++;
        if (y !== 24'h123456) begin
            miscompares++;
            $display("FAIL bypass_data: got %h want 123456", y);
        end
        vectors++;
        if (o_cur_delay !== 10'd0) begin
            miscompares++;
            $display("FAIL bypass_cur_delay: got %0d want 0", o_cur_delay);
        end
    endtask

    task automatic test_delay_change();
        logic [DATA_W-1:0] y;
        int lat;
        int exp_d [3];
        int exp_y [3];
`ifdef PREDELAY_SLEW_EN
        exp_d = '{6, 7, 8};
        exp_y = '{5, 5, 5};
`else
        exp_d = '{8, 8, 8};
        exp_y = '{3, 4, 5};
`endif
        do_reset();
        i_delay_value = 10'd5;
        for (int k = 1; k <= 10; k++) begin
            send(DATA_W'(k), y, lat);
        end
        i_delay_value = 10'd8;
        for (int i = 0; i < 3; i++) begin
            send(DATA_W'(11 + i), y, lat);
            vectors++;
            if (y !== DATA_W'(exp_y[i])) begin
                miscompares++;
                $display("FAIL change_data[%0d]: got %0d want %0d", i, y, exp_y[i]);
            end
            vectors++;
            if (o_cur_delay !== DELAY_W'(exp_d[i])) begin
                miscompares++;
                $display("FAIL change_cur_delay[%0d]: got %0d want %0d", i, o_cur_delay, exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] y;
        int n;
        do_reset();
        i_delay_value = 10'd0;
        n = 0;
        while (o_in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        i_in_data  = 24'hA5A5A5;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_data  = 24'h5A5A5A;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (o_out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_valid[%0d]: got %b want 1", c, o_out_valid);
            end
            vectors++;
            if (o_out_data !== 24'hA5A5A5) begin
                miscompares++;
                $display("FAIL hold_data[%0d]: got %h want a5a5a5", c, o_out_data);
            end
            vectors++;
            if (o_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_in_ready[%0d]: got %b want 0", c, o_in_ready);
            end
            @(posedge clk); #1;
        end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        vectors++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_hold: got valid=%b ready=%b want valid=0 ready=1",
                     o_out_valid, o_in_ready);
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        vectors++;
        if (o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL held_accept_ready: got %b want 0", o_in_ready);
        end
        @(posedge clk); #1;
        y = o_out_data;
        vectors++;
        if (o_out_valid !== 1'b1 || y !== 24'h5A5A5A) begin
            miscompares++;
            $display("FAIL held_sample_out: got valid=%b data=%h want valid=1 data=5a5a5a",
                     o_out_valid, y);
        end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_max_delay();
        logic [DATA_W-1:0] y;
        int lat;
        int exp;
        do_reset();
        i_delay_value = 10'd1023;
        for (int k = 1; k <= 2100; k++) begin
            send(DATA_W'(k), y, lat);
            exp = (k <= 1023) ? 0 : k - 1023;
            vectors++;
            if (y !== DATA_W'(exp)) begin
                miscompares++;
                $display("FAIL max_delay_data[%0d]: got %0d want %0d", k, y, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] y;
        int lat;
        int n;
        int exp;
        do_reset();
        i_delay_value = 10'd5;
        for (int k = 1; k <= 10; k++) begin
            send(DATA_W'(100 + k), y, lat);
        end
        // Reset while an output is being held: out_valid must drop at once.
        i_delay_value = 10'd7;
        i_in_data     = 24'h0000AA;
        i_in_valid    = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (o_out_valid !== 1'b0 || o_out_data !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_in_hold: got valid=%b data=%h want valid=0 data=0",
                     o_out_valid, o_out_data);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Reset while in the read cycle.
        n = 0;
        while (o_in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        i_in_data  = 24'h0000BB;
        i_in_valid = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        vectors++;
        if (o_cur_delay !== 10'd7) begin
            miscompares++;
            $display("FAIL read_cur_delay: got %0d want 7", o_cur_delay);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (o_out_valid !== 1'b0 || o_cur_delay !== 10'd5 || o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_read: got valid=%b delay=%0d ready=%b want 0/5/0",
                     o_out_valid, o_cur_delay, o_in_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        i_delay_value = 10'd5;
        @(posedge clk); #1;
        for (int k = 1; k <= 7; k++) begin
            send(DATA_W'(k), y, lat);
            exp = (k <= 5) ? 0 : k - 5;
            vectors++;
            if (y !== DATA_W'(exp)) begin
                miscompares++;
                $display("FAIL restart_data[%0d]: got %0d want %0d", k, y, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_delay();
        test_bypass();
        test_delay_change();
        test_backpressure();
        test_max_delay();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pre_delay_line.md
Name: pre_delay_line

Overview:
- Audio-path stage directly downstream of the pre-delay PIO register.
- Consumes the 10-bit pre-delay value (in samples) and delays the dry input stream by that many samples before the reverb network.
- Circular buffer in inferred synchronous RAM, with valid/ready handshakes on both sides. One sample is in flight at a time.

Parameters:
- DATA_W, 24, audio sample width (two's complement).
- DELAY_W, 10, width of delay_value; buffer depth is 2**DELAY_W.
- RESET_DELAY, 5, delay used after reset until the first sample is accepted.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- delay_value  in  DELAY_W  requested pre-delay in samples; quasi-static, driven by the PIO.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  delayed sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- cur_delay  out  DELAY_W  delay actually applied to the most recent sample.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after release.
  - out_valid=0, out_data=0, cur_delay=RESET_DELAY.
  - wr_ptr=0, fill_cnt=0, FSM=IDLE.
  - RAM contents are not reset.
- FSM states: IDLE, READ, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data and the effective delay d (see below), drive the RAM read address wr_ptr-d (mod depth), go to READ.
- READ (1 cycle, RAM read latency):
  - Write in_data at wr_ptr. The read occurs before the write (read-during-write returns old data).
  - Increment wr_ptr with wrap from 2**DELAY_W-1 to 0.
  - Increment fill_cnt, saturating at 2**DELAY_W-1.
  - Register out_data and set out_valid=1. Go to HOLD.
- Output selection in READ:
  - d==0: out_data = latched in_data (bypass).
  - fill_cnt < d (buffer not yet primed): out_data = 0.
  - Otherwise: out_data = RAM read data.
- HOLD:
  - out_valid=1, out_data stable, in_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
- Throughput and latency:
  - Accept in cycle T gives out_valid in cycle T+2. Minimum 3 cycles per sample.
  - Samples arrive at audio rate, far below this throughput.
- Delay semantics:
  - Output for sample n is input sample n-d.
  - Maximum d is 2**DELAY_W-1 (1023). No clamping is needed because the buffer depth equals the delay range.
- Delay changes:
  - delay_value is sampled only at input acceptance and never mid-sample.
  - cur_delay updates in the accept cycle.
- Simultaneous events:
  - in_valid is ignored in HOLD, even when out_ready is high in the same cycle.
  - A new sample is accepted no earlier than the cycle after out_ready is seen.
- Reset mid-operation:
  - Any state returns to IDLE. The pending output is dropped, fill_cnt=0, and earlier buffer contents are treated as silence through the fill_cnt rule.

Optional Feature:
- Macro: PREDELAY_SLEW_EN.
- Defined:
  - The effective delay d moves toward delay_value by at most 1 per accepted sample (±1 step, or hold when equal), starting from RESET_DELAY.
  - cur_delay shows the slewing value. This avoids clicks on large jumps.
- Undefined:
  - d = delay_value directly at each acceptance; the jump is immediate.

Test Plan:
- Reset with delay_value=5, feed samples 1,2,3,… with out_ready=1 -> outputs 0,0,0,0,0,1,2,3…; out_valid exactly 2 cycles after each accept.
- delay_value=0, feed 0x123456 -> out_data=0x123456 (bypass), regardless of fill_cnt.
- delay_value=1023, feed 2100 ramp samples 1..2100 -> first 1023 outputs 0; output k (k>1023) equals k-1023, including across wr_ptr wrap at 1024.
- Hold out_ready=0 for 10 cycles after an output -> out_data/out_valid stable, in_ready=0, held in_valid sample accepted only after out_ready pulse.
- Change delay_value 5->8 mid-stream (macro undefined) -> next output jumps to n-8 and cur_delay=8; with PREDELAY_SLEW_EN, cur_delay steps 6,7,8 over 3 samples.
- Assert reset_n=0 in READ -> out_valid=0 immediately, cur_delay=5; after release, outputs restart with 5 zero samples.
